// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory read channel between the fetch unit and program memory.
//
//   Handshake: the master raises imem_req together with a stable imem_addr and
//   holds both until it samples imem_ack=1 on a rising edge; imem_data is valid
//   on that same edge. imem_ack while imem_req is low carries no meaning and is
//   ignored by the master.
//
//   Signals:
//     imem_req   master -> slave  read request
//     imem_addr  master -> slave  read address (frozen while imem_req=1)
//     imem_ack   slave  -> master read data valid
//     imem_data  slave  -> master read data
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 12
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the program counter and instruction register,
//   reads program memory through fetch_unit_if, applies the controller's
//   LoadIR / IncPC / SelPC / LoadPC strobes, detects HALT (opcode 4'hF) and
//   aborts fetches that see no ack within TIMEOUT cycles.
//
//   Ports:
//     clk, CLB          clock (rising edge), asynchronous active-low reset
//     LoadIR            launch a fetch from the current PC
//     IncPC, LoadPC     PC increment / load (LoadPC wins)
//     SelPC, reg_value  load source: 1 = reg_value, 0 = IR operand field
//     imem              memory read channel (master side)
//     Opcode, operand   IR fields
//     pc_out            current PC
//     ir_valid          IR holds a freshly fetched word
//     stall             fetch outstanding
//     halted            HALT latched (cleared only by reset)
//     fetch_err         sticky fetch-timeout flag
//     dbg_state         FSM state (0 = IDLE, 1 = REQ)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int          PC_WIDTH    = 8,
    parameter int          INSTR_WIDTH = 12,
    parameter int unsigned RESET_PC    = 0,
    parameter int          TIMEOUT     = 15
) (
    input  logic                clk,
    input  logic                CLB,
    input  logic                LoadIR,
    input  logic                IncPC,
    input  logic                SelPC,
    input  logic                LoadPC,
    input  logic [PC_WIDTH-1:0] reg_value,
    fetch_unit_if.master        imem,
    output logic [3:0]          Opcode,
    output logic [PC_WIDTH-1:0] operand,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                ir_valid,
    output logic                stall,
    output logic                halted,
    output logic                fetch_err,
    output logic                dbg_state
);

    localparam int                  CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]          OP_HALT    = 4'hF;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic                   ir_valid_q, ir_valid_d;
    logic                   halted_q, halted_d;
    logic                   fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Request and stall are pure functions of the state, so an asynchronous
    // reset drops the request the moment CLB falls.
    assign imem.imem_req  = (state_q == S_REQ);
    assign imem.imem_addr = addr_q;
    assign stall          = (state_q == S_REQ);
    assign dbg_state      = state_q;

    assign Opcode    = ir_q[INSTR_WIDTH-1 -: 4];
    assign operand   = ir_q[PC_WIDTH-1:0];
    assign pc_out    = pc_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = halted_q;
    assign fetch_err = fetch_err_q;

    // Fetch FSM: next state and registered fetch outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        halted_d    = halted_q;
        fetch_err_d = fetch_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (LoadIR && !halted_q) begin
                    // Snapshot PC so later PC updates cannot disturb the fetch.
                    addr_d     = pc_q;
                    ir_valid_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (imem.imem_ack) begin
                    ir_d       = imem.imem_data;
                    ir_valid_d = 1'b1;
                    state_d    = S_IDLE;
                    if (imem.imem_data[INSTR_WIDTH-1 -: 4] == OP_HALT) begin
                        halted_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: deliver a NOP so the controller keeps moving.
                    ir_d        = '0;
                    ir_valid_d  = 1'b1;
                    fetch_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PC update runs every edge regardless of fetch state; frozen once halted.
    always_comb begin
        pc_d = pc_q;
        if (!halted_q) begin
            if (LoadPC) begin
                pc_d = SelPC ? reg_value : ir_q[PC_WIDTH-1:0];
            end else if (IncPC) begin
                pc_d = pc_q + PC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC_V;
            ir_q        <= '0;
            addr_q      <= '0;
            ir_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            addr_q      <= addr_d;
            ir_valid_q  <= ir_valid_d;
            halted_q    <= halted_d;
            fetch_err_q <= fetch_err_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed and randomized checks of fetch_unit. Program memory is driven by
//   hand from the stimulus; a transaction-level model (PC as a wrapping byte,
//   IR as the last delivered word) supplies expected values for the random part.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic       clk;
    logic       CLB;
    logic       LoadIR, IncPC, SelPC, LoadPC;
    logic [7:0] reg_value;
    logic [3:0] Opcode;
    logic [7:0] operand, pc_out;
    logic       ir_valid, stall, halted, fetch_err, dbg_state;

    fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(12)) imem_bus ();

    fetch_unit #(
        .PC_WIDTH(8), .INSTR_WIDTH(12), .RESET_PC(0), .TIMEOUT(15)
    ) dut (
        .clk(clk), .CLB(CLB),
        .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
        .reg_value(reg_value),
        .imem(imem_bus.master),
        .Opcode(Opcode), .operand(operand), .pc_out(pc_out),
        .ir_valid(ir_valid), .stall(stall), .halted(halted),
        .fetch_err(fetch_err), .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        LoadIR = 1'b0; IncPC = 1'b0; SelPC = 1'b0; LoadPC = 1'b0;
        reg_value = 8'h00;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_data = 12'h000;
    endtask

    logic [7:0]  m_pc;
    logic [11:0] m_ir;
    logic [11:0] rdata;
    logic [7:0]  rval;
    logic        rinc;
    int          act, lat, n;

    initial begin
        // ---------------- reset ----------------
        clear_inputs();
        CLB = 1'b0;
        repeat (2) tick();
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_opcode", Opcode, 4'h0);
        chk("rst_req", imem_bus.imem_req, 1'b0);
        chk("rst_addr", imem_bus.imem_addr, 8'h00);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_err", fetch_err, 1'b0);
        @(negedge clk); CLB = 1'b1;
        tick();

        // ---------------- first fetch, ack after 1 cycle ----------------
        LoadIR = 1'b1; tick(); LoadIR = 1'b0;
        chk("f1_req", imem_bus.imem_req, 1'b1);
        chk("f1_addr", imem_bus.imem_addr, 8'h00);
        chk("f1_stall", stall, 1'b1);
        chk("f1_state", dbg_state, 1'b1);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 12'h1A5; tick();
        imem_bus.imem_ack = 1'b0;
        chk("f1_req_drop", imem_bus.imem_req, 1'b0);
        chk("f1_opcode", Opcode, 4'h1);
        chk("f1_operand", operand, 8'hA5);
        chk("f1_ir_valid", ir_valid, 1'b1);
        chk("f1_stall_low", stall, 1'b0);

        // ---------------- PC control ----------------
        LoadPC = 1'b1; SelPC = 1'b1; reg_value = 8'hFF; tick(); clear_inputs();
        chk("pc_load_ff", pc_out, 8'hFF);
        IncPC = 1'b1; tick(); IncPC = 1'b0;
        chk("pc_wrap", pc_out, 8'h00);
        LoadPC = 1'b1; SelPC = 1'b1; reg_value = 8'h3C; tick(); clear_inputs();
        chk("pc_reg_3c", pc_out, 8'h3C);
        LoadIR = 1'b1; tick(); LoadIR = 1'b0;
        chk("f2_addr", imem_bus.imem_addr, 8'h3C);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 12'h277; tick();
        imem_bus.imem_ack = 1'b0;
        chk("f2_operand", operand, 8'h77);
        LoadPC = 1'b1; SelPC = 1'b0; IncPC = 1'b1; tick(); clear_inputs();
        chk("pc_load_prio", pc_out, 8'h77);

        // ---------------- wait states (ack 4 cycles after launch) ----------------
        LoadIR = 1'b1; tick(); LoadIR = 1'b0;
        chk("ws_addr0", imem_bus.imem_addr, 8'h77);
        chk("ws_stall0", stall, 1'b1);
        IncPC = 1'b1; tick(); IncPC = 1'b0;
        chk("ws_pc_moves", pc_out, 8'h78);
        chk("ws_addr1", imem_bus.imem_addr, 8'h77);
        LoadIR = 1'b1; tick(); LoadIR = 1'b0;
        chk("ws_stall2", stall, 1'b1);
        chk("ws_addr2", imem_bus.imem_addr, 8'h77);
        tick();
        chk("ws_stall3", stall, 1'b1);
        chk("ws_ir_hold", operand, 8'h77);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 12'h3C4; tick();
        imem_bus.imem_ack = 1'b0;
        chk("ws_req_drop", imem_bus.imem_req, 1'b0);
        chk("ws_opcode", Opcode, 4'h3);
        chk("ws_operand", operand, 8'hC4);
        tick();
        chk("ws_no_queued_req", imem_bus.imem_req, 1'b0);

        // ---------------- LoadIR + LoadPC on the same edge ----------------
        LoadIR = 1'b1; LoadPC = 1'b1; SelPC = 1'b1; reg_value = 8'h10; tick(); clear_inputs();
        chk("same_addr_old_pc", imem_bus.imem_addr, 8'h78);
        chk("same_pc_new", pc_out, 8'h10);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 12'h6EE; tick();
        imem_bus.imem_ack = 1'b0;
        chk("same_opcode", Opcode, 4'h6);

        // ---------------- timeout ----------------
        LoadIR = 1'b1; tick(); LoadIR = 1'b0;
        chk("to_ir_valid_clr", ir_valid, 1'b0);
        chk("to_err_before", fetch_err, 1'b0);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk($sformatf("to_req_held_%0d", i), imem_bus.imem_req, 1'b1);
        end
        tick();
        chk("to_req_drop", imem_bus.imem_req, 1'b0);
        chk("to_opcode_nop", Opcode, 4'h0);
        chk("to_err", fetch_err, 1'b1);
        chk("to_ir_valid", ir_valid, 1'b1);
        LoadIR = 1'b1; tick(); LoadIR = 1'b0;
        tick();
        imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 12'h5AB; tick();
        imem_bus.imem_ack = 1'b0;
        chk("to_refetch_opcode", Opcode, 4'h5);
        chk("to_err_sticky", fetch_err, 1'b1);

        // ---------------- randomized sequence against the model ----------------
        CLB = 1'b0; #1;
        chk("rst2_err", fetch_err, 1'b0);
        @(negedge clk); CLB = 1'b1;
        tick();
        m_pc = 8'h00;
        m_ir = 12'h000;
        for (int it = 0; it < 60; it++) begin
            act = $urandom_range(0, 3);
            case (act)
                0: begin
                    n = $urandom_range(1, 4);
                    IncPC = 1'b1;
                    repeat (n) tick();
                    IncPC = 1'b0;
                    m_pc = m_pc + 8'(n);
                end
                1: begin
                    rval = 8'($urandom);
                    LoadPC = 1'b1; SelPC = 1'b1; reg_value = rval;
                    IncPC = 1'($urandom_range(0, 1));
                    tick(); clear_inputs();
                    m_pc = rval;
                end
                2: begin
                    LoadPC = 1'b1; SelPC = 1'b0; reg_value = 8'($urandom);
                    tick(); clear_inputs();
                    m_pc = m_ir[7:0];
                end
                default: begin
                    lat   = $urandom_range(1, 6);
                    rdata = {4'($urandom_range(0, 14)), 8'($urandom)};
                    LoadIR = 1'b1; tick(); LoadIR = 1'b0;
                    chk("rnd_addr", imem_bus.imem_addr, m_pc);
                    for (int w = 1; w <= lat; w++) begin
                        rinc = 1'($urandom_range(0, 1));
                        IncPC = rinc;
                        imem_bus.imem_ack  = (w == lat);
                        imem_bus.imem_data = (w == lat) ? rdata : 12'($urandom);
                        tick();
                        m_pc = m_pc + 8'(rinc);
                        chk("rnd_req", imem_bus.imem_req, (w == lat) ? 1'b0 : 1'b1);
                    end
                    clear_inputs();
                    m_ir = rdata;
                    chk("rnd_opcode", Opcode, m_ir[11:8]);
                    chk("rnd_operand", operand, m_ir[7:0]);
                    chk("rnd_ir_valid", ir_valid, 1'b1);
                end
            endcase
            chk("rnd_pc", pc_out, m_pc);
        end

        // ---------------- halt ----------------
        LoadIR = 1'b1; tick(); LoadIR = 1'b0;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 12'hF00; tick();
        imem_bus.imem_ack = 1'b0;
        chk("halt_set", halted, 1'b1);
        chk("halt_opcode", Opcode, 4'hF);
        LoadIR = 1'b1; IncPC = 1'b1; LoadPC = 1'b1; SelPC = 1'b1; reg_value = 8'h55;
        tick();
        chk("halt_no_req", imem_bus.imem_req, 1'b0);
        tick(); clear_inputs();
        chk("halt_no_stall", stall, 1'b0);
        chk("halt_pc_frozen", pc_out, m_pc);
        #2 CLB = 1'b0; #1;
        chk("halt_rst_clear", halted, 1'b0);
        chk("halt_rst_pc", pc_out, 8'h00);
        @(negedge clk); CLB = 1'b1;
        tick();

        // ---------------- async reset during a request ----------------
        LoadIR = 1'b1; tick(); LoadIR = 1'b0;
        chk("ar_req_up", imem_bus.imem_req, 1'b1);
        #2 CLB = 1'b0; #1;
        chk("ar_req_async_drop", imem_bus.imem_req, 1'b0);
        chk("ar_stall_drop", stall, 1'b0);
        @(negedge clk); CLB = 1'b1;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 12'h123; tick();
        imem_bus.imem_ack = 1'b0;
        chk("ar_late_ack_opcode", Opcode, 4'h0);
        chk("ar_late_ack_operand", operand, 8'h00);
        chk("ar_late_ack_valid", ir_valid, 1'b0);
        chk("ar_late_ack_req", imem_bus.imem_req, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
